bcd_scan_display: RTL and testbench

// - Multi-digit successor to the single-value two-digit decoder: converts an unsigned binary value to BCD sequentially (double-dabble, one bit per clock) and drives NUM_DIGITS multiplexed 7-segment digits through a shared segment bus.
// - Sits between the calculator result register and the board display pins; the result path pulses load when a new value is ready.

---
 rtl/bcd_scan_display.sv | 178 +++++++++++++++++
 tb/tb_bcd_scan_display.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Sequential double-dabble binary-to-BCD converter driving a scanned 7-seg display.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bcd_scan_display #(
  parameter int VAL_W       = 14,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VAL_W-1:0]      val,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  // enough nibbles for any VAL_W-bit value, plus one spare
  localparam int BCD_F = (VAL_W * 30103 + 99999) / 100000 + 1;
  localparam int BCD_N = (BCD_F > NUM_DIGITS) ? BCD_F : NUM_DIGITS;
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] LIMIT = 64'd10 ** NUM_DIGITS;

  localparam logic [6:0] SEG_DASH  = 7'b011_1111;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [VAL_W-1:0] bin_q, bin_d;
  logic [VAL_W-1:0] cap_q, cap_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;

  logic [REF_W-1:0] ref_q;
  logic [IDX_W-1:0] idx_q;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    cap_d   = cap_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    adj     = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          bin_d   = val;
          cap_d   = val;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        for (int i = 0; i < BCD_N; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
          end
        end
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VAL_W - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        ovf_d   = 64'(cap_q) >= LIMIT;
        dig_d   = bcd_q[NUM_DIGITS*4-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      cap_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cap_q   <= cap_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q <= '0;
      idx_q <= '0;
    end else if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_q <= '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b100_0000;
      4'd1:    s = 7'b111_1001;
      4'd2:    s = 7'b010_0100;
      4'd3:    s = 7'b011_0000;
      4'd4:    s = 7'b001_1001;
      4'd5:    s = 7'b001_0010;
      4'd6:    s = 7'b000_0010;
      4'd7:    s = 7'b111_1000;
      4'd8:    s = 7'b000_0000;
      4'd9:    s = 7'b001_0000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic blank;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  zhi;

  // digit k is a leading zero when it and every digit above it are zero
  always_comb begin
    lz  = '0;
    zhi = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zhi   = zhi & (dig_q[k] == 4'd0);
      lz[k] = zhi;
    end
  end

  assign blank = lz[idx_q];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg = dec7(dig_q[idx_q]);
    if (ovf_q) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end
  end

  assign an       = ~(NUM_DIGITS'(1) << idx_q);
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized and directed bench for bcd_scan_display against an arithmetic model.
// Honors LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_scan_display;

  localparam int VAL_W = 14;
  localparam int ND    = 4;
  localparam int RD    = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [13:0]   val;
  logic          load;
  logic          busy;
  logic          overflow;
  logic [6:0]    seg;
  logic [3:0]    an;

  bcd_scan_display #(
    .VAL_W(VAL_W),
    .NUM_DIGITS(ND),
    .REFRESH_DIV(RD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .val(val),
    .load(load),
    .busy(busy),
    .overflow(overflow),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  logic [6:0] segt [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  int ntests = 0;
  int nfail  = 0;

  // model: cycles-since-reset, remaining busy cycles, pending and shown value
  int scnt  = 0;
  int mbusy = 0;
  int pend  = 0;
  int mdisp = 0;
  bit movf  = 0;

  function automatic int p10(int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(int idx);
    int d;
    d = (mdisp / p10(idx)) % 10;
    if (movf) return 7'b011_1111;
    if (LZB && idx > 0 && mdisp < p10(idx)) return 7'b111_1111;
    return segt[d];
  endfunction

  task automatic check();
    int         idx;
    logic [3:0] ea;
    logic [6:0] es;
    logic       eb;
    idx    = (scnt / RD) % ND;
    ea     = 4'b1111;
    ea[idx] = 1'b0;
    es     = exp_seg(idx);
    eb     = (mbusy != 0);
    ntests++;
    assert (busy === eb) else begin
      nfail++;
      $error("FAIL busy got %b exp %b t=%0t", busy, eb, $time);
    end
    ntests++;
    assert (overflow === movf) else begin
      nfail++;
      $error("FAIL overflow got %b exp %b t=%0t", overflow, movf, $time);
    end
    ntests++;
    assert (an === ea) else begin
      nfail++;
      $error("FAIL an got %b exp %b t=%0t", an, ea, $time);
    end
    ntests++;
    assert (seg === es) else begin
      nfail++;
      $error("FAIL seg got %b exp %b disp=%0d t=%0t", seg, es, mdisp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      scnt  = 0;
      mbusy = 0;
      mdisp = 0;
      movf  = 0;
    end else begin
      scnt++;
      if (mbusy > 0) begin
        mbusy--;
        if (mbusy == 0) begin
          mdisp = pend % p10(ND);
          movf  = (pend >= p10(ND));
        end
      end else if (load) begin
        mbusy = VAL_W + 1;
        pend  = int'(val);
      end
    end
    #1;
    check();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_load(int v);
    val  = 14'(v);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    val   = '0;
    run(3);
    rst_n = 1'b1;
    run(5);

    do_load(1234);
    run(36);

    do_load(9999);
    run(20);
    do_load(10000);
    run(20);
    do_load(16383);
    run(20);
    do_load(0);
    run(20);

    // load pulse while shifting is ignored
    do_load(5678);
    run(2);
    do_load(1111);
    run(20);

    // load on the commit cycle is ignored, next cycle accepted
    do_load(2468);
    run(14);
    do_load(1357);
    do_load(42);
    run(30);

    // reset mid-conversion aborts it
    do_load(4321);
    run(6);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(30);

    for (int i = 0; i < 40; i++) begin
      int v;
      int g;
      v = int'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 99));
      do_load(v);
      g = int'($urandom_range(0, 13));
      run(g);
      if ($urandom_range(0, 1) == 1) begin
        do_load(int'($urandom_range(0, 16383)));
      end else begin
        val = 14'($urandom);
        step();
      end
      run(int'($urandom_range(14, 24)) - g);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
